// File: rtl/ihp_ram_arbiter_if.sv
// Requester and SRAM-macro bundle for the shared-RAM arbiter.
// slave = arbiter side, master = requesters/macro side.
`timescale 1ns/1ps
interface ihp_ram_arbiter_if #(
  parameter int AW  = 10,
  parameter int DW  = 64,
  parameter int NBE = 8
);
  logic           a_req;
  logic [NBE-1:0] a_we;
  logic [AW-1:0]  a_addr;
  logic [DW-1:0]  a_wdata;
  logic           a_gnt;
  logic           a_rvalid;
  logic [DW-1:0]  a_rdata;

  logic           b_req;
  logic [NBE-1:0] b_we;
  logic [AW-1:0]  b_addr;
  logic [DW-1:0]  b_wdata;
  logic           b_gnt;
  logic           b_rvalid;
  logic [DW-1:0]  b_rdata;

  logic           mem_men;
  logic           mem_wen;
  logic           mem_ren;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_din;
  logic [DW-1:0]  mem_bm;
  logic [DW-1:0]  mem_dout;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_dout,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_men, mem_wen, mem_ren,
    output mem_addr, mem_din, mem_bm
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_dout,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_men, mem_wen, mem_ren,
    input  mem_addr, mem_din, mem_bm
  );
endinterface

// File: rtl/ihp_ram_arbiter.sv
// Round-robin two-port arbiter in front of a single-port SRAM macro,
// with registered command stage and a bulk-clear sequencer.
`timescale 1ns/1ps
module ihp_ram_arbiter #(
  parameter int            AW        = 10,
  parameter int            DW        = 64,
  parameter int            NBE       = 8,
  parameter logic [DW-1:0] CLEAR_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_start,
  output logic clr_busy,
  output logic clr_done,
  ihp_ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           pref_b_q, pref_b_d;
  logic           rdy_q;
  logic           men_q, men_d;
  logic           wen_q, wen_d;
  logic           ren_q, ren_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  din_q, din_d;
  logic [DW-1:0]  bm_q, bm_d;
  logic [1:0]     tag1_q, tag1_d;
  logic [1:0]     tag2_q;

  logic           gnt_a, gnt_b, is_rd;
  logic [NBE-1:0] sel_we;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pref_b_d = pref_b_q;
    men_d    = 1'b0;
    wen_d    = 1'b0;
    ren_d    = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    bm_d     = '0;
    tag1_d   = '0;
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (rdy_q) begin
          gnt_a = bus.a_req &&
                  (!bus.b_req || !pref_b_q);
          gnt_b = bus.b_req && !gnt_a;
        end
      end
      CLEAR: begin
        men_d  = 1'b1;
        wen_d  = 1'b1;
        addr_d = cnt_q[AW-1:0];
        din_d  = CLEAR_VAL;
        bm_d   = '1;
        cnt_d  = cnt_q + (AW+1)'(1);
        // extra MSB flags the wrap past the last word
        if (cnt_d[AW]) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    sel_we    = gnt_b ? bus.b_we    : bus.a_we;
    sel_addr  = gnt_b ? bus.b_addr  : bus.a_addr;
    sel_wdata = gnt_b ? bus.b_wdata : bus.a_wdata;
    is_rd     = ~|sel_we;

    if (gnt_a || gnt_b) begin
      pref_b_d = gnt_a;
      men_d    = 1'b1;
      wen_d    = !is_rd;
      ren_d    = is_rd;
      addr_d   = sel_addr;
      din_d    = sel_wdata;
      for (int i = 0; i < NBE; i++)
        bm_d[8*i +: 8] = {8{sel_we[i]}};
      tag1_d   = {gnt_b & is_rd, gnt_a & is_rd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pref_b_q <= 1'b0;
      rdy_q    <= 1'b0;
      men_q    <= 1'b0;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      bm_q     <= '0;
      tag1_q   <= '0;
      tag2_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pref_b_q <= pref_b_d;
      rdy_q    <= 1'b1;
      men_q    <= men_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      bm_q     <= bm_d;
      tag1_q   <= tag1_d;
      tag2_q   <= tag1_q;
    end
  end

  assign bus.a_gnt    = gnt_a;
  assign bus.b_gnt    = gnt_b;
  assign bus.a_rvalid = tag2_q[0];
  assign bus.b_rvalid = tag2_q[1];
  assign bus.a_rdata  = tag2_q[0] ? bus.mem_dout : '0;
  assign bus.b_rdata  = tag2_q[1] ? bus.mem_dout : '0;

  assign bus.mem_men  = men_q;
  assign bus.mem_wen  = wen_q;
  assign bus.mem_ren  = ren_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;
  assign bus.mem_bm   = bm_q;

  assign clr_busy = (state_q == CLEAR);
  assign clr_done = (state_q == DONE);

endmodule

// File: tb/tb_ihp_ram_arbiter.sv
// Directed bench for ihp_ram_arbiter: behavioural SRAM, read scoreboard
// with due-cycle check, and direct checks of grants and the clear sequence.
`timescale 1ns/1ps
module tb_ihp_ram_arbiter;
  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int NBE = 8;
  localparam logic [63:0] CV = 64'h0;
  localparam logic [63:0] V5 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] V7 = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] VD = 64'hDEAD_BEEF_CAFE_F00D;

  typedef struct {logic [63:0] d; int due;} exp_t;
  typedef struct {bit who; int cyc;} gnt_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_start;
  logic clr_busy;
  logic clr_done;
  int   nvec = 0;
  int   nmis = 0;
  int   cyc  = 0;
  exp_t qa[$];
  exp_t qb[$];
  gnt_t gl[$];
  logic [63:0] sram [1024];

  ihp_ram_arbiter_if #(.AW(AW), .DW(DW), .NBE(NBE)) bus ();

  ihp_ram_arbiter #(
    .AW(AW), .DW(DW), .NBE(NBE), .CLEAR_VAL(CV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr_start(clr_start),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.mem_men) begin
      if (bus.mem_wen)
        sram[bus.mem_addr] <= (sram[bus.mem_addr] & ~bus.mem_bm)
                            | (bus.mem_din & bus.mem_bm);
      if (bus.mem_ren)
        bus.mem_dout <= sram[bus.mem_addr];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic rv(input bit who);
    logic        v;
    logic [63:0] d;
    exp_t        e;
    v = who ? bus.b_rvalid : bus.a_rvalid;
    d = who ? bus.b_rdata : bus.a_rdata;
    if (v !== 1'b1) return;
    nvec++;
    if ((who ? qb.size() : qa.size()) == 0) begin
      nmis++;
      $display("FAIL rvalid_%s unexpected: cycle %0d data %h",
               who ? "B" : "A", cyc, d);
      return;
    end
    if (who) e = qb.pop_front();
    else     e = qa.pop_front();
    if (d !== e.d || cyc != e.due) begin
      nmis++;
      $display("FAIL rdata_%s: got %h at cycle %0d want %h at cycle %0d",
               who ? "B" : "A", d, cyc, e.d, e.due);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        rv(1'b0);
        rv(1'b1);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drained();
    chk("scoreboard_drained", 64'(qa.size() + qb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    chk("reset_ctrl", 64'({bus.a_gnt, bus.b_gnt, bus.a_rvalid,
        bus.b_rvalid, clr_busy, clr_done, bus.mem_men,
        bus.mem_wen, bus.mem_ren}), 64'd0);
    chk("reset_data", bus.a_rdata | bus.b_rdata | bus.mem_din
        | bus.mem_bm | 64'(bus.mem_addr), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
  task automatic acc(input bit who, input logic [7:0] we,
                     input logic [9:0] addr, input logic [63:0] wd,
                     input logic [63:0] ed, output int waited);
    bit g;
    exp_t e;
    g = 1'b0;
    waited = 0;
    if (who) begin
      bus.b_req = 1'b1; bus.b_we = we;
      bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we;
      bus.a_addr = addr; bus.a_wdata = wd;
    end
    for (int k = 0; k < 2000 && !g; k++) begin
      @(negedge clk);
      g = who ? bus.b_gnt : bus.a_gnt;
      if (!g) waited++;
    end
    chk(who ? "grant_B" : "grant_A", 64'(g), 64'd1);
    if (g) begin
      gl.push_back('{who, cyc});
      if (we == 8'h00) begin
        e = '{ed, cyc + 2};
        if (who) qb.push_back(e);
        else     qa.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (who) bus.b_req = 1'b0;
    else     bus.a_req = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 1100 && !seen; k++) begin
      @(negedge clk);
      seen = clr_done;
    end
    chk("clr_done_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
  endtask

  int w;
  int busy, done, wc, bad, hit;

  initial begin
    rst_n = 1'b1;
    clr_start = 1'b0;
    bus.a_req = 1'b0; bus.a_we = '0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = '0; bus.b_addr = '0; bus.b_wdata = '0;
    fork monitor(); join_none
    #2;
    do_reset();

    // 1: full write then read on A
    acc(1'b0, 8'hFF, 10'd5, V5, 64'd0, w);
    chk("t1_wr_no_wait", 64'(w), 64'd0);
    acc(1'b0, 8'h00, 10'd5, 64'd0, V5, w);
    chk("t1_rd_no_wait", 64'(w), 64'd0);
    idle(3);

    // 2: byte-masked write from B
    acc(1'b0, 8'hFF, 10'd7, '1, 64'd0, w);
    acc(1'b1, 8'h0F, 10'd7, 64'd0, 64'd0, w);
    @(negedge clk);
    chk("t2_mem_bm", bus.mem_bm, 64'h0000_0000_FFFF_FFFF);
    chk("t2_mem_cmd", 64'({bus.mem_men, bus.mem_wen, bus.mem_ren}),
        64'b110);
    chk("t2_mem_addr", 64'(bus.mem_addr), 64'd7);
    @(posedge clk);
    #1;
    acc(1'b1, 8'h00, 10'd7, 64'd0, V7, w);
    idle(3);
    drained();

    // 3: both requesting continuously after reset
    do_reset();
    gl.delete();
    fork
      begin
        int wa;
        acc(1'b0, 8'h00, 10'd5, 64'd0, V5, wa);
        acc(1'b0, 8'h00, 10'd7, 64'd0, V7, wa);
        acc(1'b0, 8'h00, 10'd5, 64'd0, V5, wa);
      end
      begin
        int wb;
        acc(1'b1, 8'h00, 10'd7, 64'd0, V7, wb);
        acc(1'b1, 8'h00, 10'd5, 64'd0, V5, wb);
        acc(1'b1, 8'h00, 10'd7, 64'd0, V7, wb);
      end
    join
    chk("t3_grant_count", 64'(gl.size()), 64'd6);
    for (int i = 0; i < gl.size(); i++) begin
      chk("t3_grant_owner", 64'(gl[i].who), 64'(i % 2));
      chk("t3_grant_cycle", 64'(gl[i].cyc), 64'(gl[0].cyc + i));
    end
    idle(3);
    drained();

    // 4: clear wins over a pending B request
    bus.b_req = 1'b1; bus.b_we = '0; bus.b_addr = 10'd9;
    clr_start = 1'b1;
    @(negedge clk);
    chk("t4_b_gnt_blocked", 64'(bus.b_gnt), 64'd0);
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    busy = 0; done = 0; wc = 0; bad = 0;
    for (int k = 0; k < 1100 && done == 0; k++) begin
      @(negedge clk);
      if (clr_busy) busy++;
      if (clr_done) done++;
      if (bus.b_gnt || bus.a_gnt) bad++;
      if (bus.mem_men && bus.mem_wen) begin
        if (bus.mem_addr != wc[9:0] || bus.mem_bm != '1 ||
            bus.mem_din != CV) bad++;
        wc++;
      end
    end
    chk("t4_busy_cycles", 64'(busy), 64'd1024);
    chk("t4_done_pulses", 64'(done), 64'd1);
    chk("t4_clear_writes", 64'(wc), 64'd1024);
    chk("t4_clear_errors", 64'(bad), 64'd0);
    @(negedge clk);
    chk("t4_b_gnt_after", 64'({bus.b_gnt, clr_done}), 64'b10);
    if (bus.b_gnt) qb.push_back('{CV, cyc + 2});
    @(posedge clk);
    #1;
    bus.b_req = 1'b0;
    acc(1'b0, 8'h00, 10'd5, 64'd0, CV, w);
    acc(1'b1, 8'h00, 10'd1023, 64'd0, CV, w);
    acc(1'b0, 8'h00, 10'd0, 64'd0, CV, w);
    acc(1'b1, 8'h00, 10'd7, 64'd0, CV, w);
    idle(3);
    drained();

    // 5: read in flight as the clear starts
    acc(1'b0, 8'hFF, 10'd20, VD, 64'd0, w);
    acc(1'b0, 8'h00, 10'd20, 64'd0, VD, w);
    clr_start = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    @(negedge clk);
    chk("t5_rvalid_while_busy", 64'({clr_busy, bus.a_rvalid}), 64'b11);
    @(posedge clk);
    #1;
    wait_done();
    idle(3);
    drained();

    // 6a: reset with a read outstanding
    acc(1'b0, 8'h00, 10'd20, 64'd0, CV, w);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_no_rvalid", 64'({bus.a_rvalid, bus.b_rvalid}), 64'd0);
    end
    @(posedge clk);
    #1;

    // 6b: reset in the middle of a clear, then restart
    clr_start = 1'b1;
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    hit = 0;
    for (int k = 0; k < 1100 && hit == 0; k++) begin
      @(negedge clk);
      if (bus.mem_wen && bus.mem_addr == 10'd300) hit = 1;
    end
    chk("t6_reached_300", 64'(hit), 64'd1);
    #1;
    do_reset();
    clr_start = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_restart_addr0",
        {62'd0, bus.mem_wen, 1'b0} | 64'(bus.mem_addr), 64'd2);
    @(posedge clk);
    #1;
    wait_done();
    acc(1'b1, 8'h00, 10'd900, 64'd0, CV, w);
    idle(4);
    drained();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
